// File: rtl/merge_n_pkg.sv
// Shared types and helpers for the M-input 2-phase bundled-data merge.
package merge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic RR_MODE    = 1'b1;
  localparam logic FIXED_MODE = 1'b0;

  // Index width for M channels; a single channel still needs one bit.
  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/merge_n_if.sv
// Bundled-data channel group: M input channels in, one output channel out.
interface merge_n_if #(
  parameter int N = 1,
  parameter int M = 2
);
  logic [M-1:0]   r_i;
  logic [M-1:0]   a_i;
  logic [M*N-1:0] d_i;
  logic           r_o;
  logic           a_o;
  logic [N-1:0]   d_o;

  // slave: the merge itself; master: producers plus consumer around it.
  modport slave  (input r_i, d_i, a_o, output a_i, r_o, d_o);
  modport master (output r_i, d_i, a_o, input a_i, r_o, d_o);
endinterface

// File: rtl/merge_n_arb_rr.sv
// Combinational arbiter: round-robin from a pointer, or lowest-index-first.
module arb_rr
  import merge_pkg::*;
#(
  parameter int M  = 2,
  parameter int GW = idx_w(M)
) (
  input  logic [M-1:0]  pend,
  input  logic [GW-1:0] ptr,
  input  logic          mode,
  output logic [M-1:0]  win_oh,
  output logic [GW-1:0] win_idx,
  output logic          any_pend
);

  localparam logic [GW:0] M_EXT = (GW+1)'(M);

  logic [GW-1:0]  start;
  logic [2*M-1:0] rot;
  logic [GW-1:0]  offset;
  logic [GW:0]    sum;

  assign start    = (mode == RR_MODE) ? ptr : '0;
  assign any_pend = |pend;

  // Rotate so the search start lands at bit 0, then take the lowest set bit.
  always_comb begin
    rot    = {pend, pend} >> start;
    offset = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (rot[i]) offset = GW'(i);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= M_EXT) sum = sum - M_EXT;
    win_idx = sum[GW-1:0];
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_oh
    assign win_oh[gi] = any_pend && (win_idx == GW'(gi));
  end

endmodule

// File: rtl/merge_n.sv
// Clocked M-input merge for 2-phase bundled-data channels; one token in flight
// on the output at a time, winner acknowledged only after the consumer acks.
module merge_n
  import merge_pkg::*;
#(
  parameter int   N    = 1,
  parameter int   M    = 2,
  parameter logic RR   = 1'b1,
  parameter logic SYNC = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  merge_n_if.slave            ch,
  output logic [idx_w(M)-1:0] grant,
  output logic                busy,
  output logic                proto_err
);

  localparam int GW = idx_w(M);

  logic [M-1:0]  r_sync;
  logic          a_sync;

  state_t        state_reg, state_next;
  logic          r_o_reg, r_o_next;
  logic [M-1:0]  a_i_reg, a_i_next;
  logic [N-1:0]  d_o_reg, d_o_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic          busy_reg, busy_next;
  logic [GW-1:0] ptr_reg, ptr_next;
  logic          err_reg, err_next;

  logic [M-1:0]  pend;
  logic [M-1:0]  win_oh;
  logic [GW-1:0] win_idx;
  logic          any_pend;
  logic [N-1:0]  win_data;
  logic [M-1:0]  served_oh;

  if (SYNC) begin : g_sync
    for (genvar gi = 0; gi < M; gi++) begin : g_req
      logic meta_reg, sync_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= ch.r_i[gi];
          sync_reg <= meta_reg;
        end
      end
      assign r_sync[gi] = sync_reg;
    end

    logic ack_meta_reg, ack_sync_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ack_meta_reg <= 1'b0;
        ack_sync_reg <= 1'b0;
      end else begin
        ack_meta_reg <= ch.a_o;
        ack_sync_reg <= ack_meta_reg;
      end
    end
    assign a_sync = ack_sync_reg;
  end else begin : g_nosync
    assign r_sync = ch.r_i;
    assign a_sync = ch.a_o;
  end

  // A channel is pending while its request phase differs from its ack phase.
  assign pend = r_sync ^ a_i_reg;

  arb_rr #(
    .M  (M),
    .GW (GW)
  ) u_arb (
    .pend     (pend),
    .ptr      (ptr_reg),
    .mode     (RR),
    .win_oh   (win_oh),
    .win_idx  (win_idx),
    .any_pend (any_pend)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < M; i++) begin
      if (win_oh[i]) win_data = win_data | ch.d_i[i*N +: N];
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_served
    assign served_oh[gi] = (grant_reg == GW'(gi));
  end

  always_comb begin
    state_next = state_reg;
    r_o_next   = r_o_reg;
    a_i_next   = a_i_reg;
    d_o_next   = d_o_reg;
    grant_next = grant_reg;
    busy_next  = busy_reg;
    ptr_next   = ptr_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        // Nothing is outstanding, so any phase difference is a spurious ack.
        if (a_sync != r_o_reg) err_next = 1'b1;
        if (any_pend) begin
          d_o_next   = win_data;
          r_o_next   = ~r_o_reg;
          grant_next = win_idx;
          busy_next  = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (a_sync == r_o_reg) begin
          a_i_next   = a_i_reg ^ served_oh;
          busy_next  = 1'b0;
          state_next = IDLE;
          if (RR == RR_MODE) begin
            ptr_next = (grant_reg == GW'(M - 1)) ? '0 : grant_reg + GW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      r_o_reg   <= 1'b0;
      a_i_reg   <= '0;
      d_o_reg   <= '0;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
      ptr_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_o_reg   <= r_o_next;
      a_i_reg   <= a_i_next;
      d_o_reg   <= d_o_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
      ptr_reg   <= ptr_next;
      err_reg   <= err_next;
    end
  end

  assign ch.r_o     = r_o_reg;
  assign ch.a_i     = a_i_reg;
  assign ch.d_o     = d_o_reg;
  assign grant      = grant_reg;
  assign busy       = busy_reg;
  assign proto_err  = err_reg;

endmodule

// File: tb/tb_merge_n.sv
// Directed bench for merge_n: round-robin, fixed-priority and synchronised variants.
module tb_merge_n;

  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  merge_n_if #(.N(N), .M(M)) if_rr ();
  merge_n_if #(.N(N), .M(M)) if_fp ();
  merge_n_if #(.N(N), .M(M)) if_sy ();

  logic [1:0] g_rr, g_fp, g_sy;
  logic       b_rr, b_fp, b_sy;
  logic       e_rr, e_fp, e_sy;

  merge_n #(.N(N), .M(M), .RR(1'b1), .SYNC(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .ch(if_rr), .grant(g_rr), .busy(b_rr), .proto_err(e_rr));
  merge_n #(.N(N), .M(M), .RR(1'b0), .SYNC(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .ch(if_fp), .grant(g_fp), .busy(b_fp), .proto_err(e_fp));
  merge_n #(.N(N), .M(M), .RR(1'b1), .SYNC(1'b1)) dut_sy (
    .clk(clk), .rst(rst), .ch(if_sy), .grant(g_sy), .busy(b_sy), .proto_err(e_sy));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_env();
    if_rr.r_i = '0; if_rr.d_i = '0; if_rr.a_o = 1'b0;
    if_fp.r_i = '0; if_fp.d_i = '0; if_fp.a_o = 1'b0;
    if_sy.r_i = '0; if_sy.d_i = '0; if_sy.a_o = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_env();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  logic       ro;
  logic [3:0] ai;

  initial begin
    do_reset();
    chk("rst_r_o",   32'(if_rr.r_o), 32'h0);
    chk("rst_a_i",   32'(if_rr.a_i), 32'h0);
    chk("rst_d_o",   32'(if_rr.d_o), 32'h0);
    chk("rst_grant", 32'(g_rr), 32'h0);
    chk("rst_busy",  32'(b_rr), 32'h0);
    chk("rst_err",   32'(e_rr), 32'h0);

    // Async reset while a token is outstanding.
    if_rr.d_i[7:0] = 8'h5A;
    if_rr.r_i[0]   = 1'b1;
    tick();
    chk("mid_send_r_o", 32'(if_rr.r_o), 32'h1);
    chk("mid_send_d_o", 32'(if_rr.d_o), 32'h5A);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_r_o",  32'(if_rr.r_o), 32'h0);
    chk("async_rst_d_o",  32'(if_rr.d_o), 32'h0);
    chk("async_rst_busy", 32'(b_rr), 32'h0);
    chk("async_rst_a_i",  32'(if_rr.a_i), 32'h0);
    clear_env();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_no_r_o", 32'(if_rr.r_o), 32'h0);

    // Single channel, one-cycle latency each way.
    if_rr.d_i[23:16] = 8'hA5;
    if_rr.r_i[2]     = 1'b1;
    tick();
    chk("single_r_o",   32'(if_rr.r_o), 32'h1);
    chk("single_d_o",   32'(if_rr.d_o), 32'hA5);
    chk("single_grant", 32'(g_rr), 32'h2);
    chk("single_busy",  32'(b_rr), 32'h1);
    chk("single_a_i_0", 32'(if_rr.a_i), 32'h0);
    if_rr.a_o = 1'b1;
    tick();
    chk("single_a_i",  32'(if_rr.a_i), 32'h4);
    chk("single_idle", 32'(b_rr), 32'h0);

    // Simultaneous requests from pointer 0.
    do_reset();
    ro = 1'b0;
    ai = 4'h0;
    if_rr.d_i = 32'h13121110;
    if_rr.r_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      ro = ~ro;
      chk($sformatf("sim%0d_grant", k), 32'(g_rr), 32'(k));
      chk($sformatf("sim%0d_d_o", k),   32'(if_rr.d_o), 32'h10 + 32'(k));
      chk($sformatf("sim%0d_r_o", k),   32'(if_rr.r_o), 32'(ro));
      if_rr.a_o = ro;
      tick();
      ai[k] = 1'b1;
      chk($sformatf("sim%0d_a_i", k), 32'(if_rr.a_i), 32'(ai));
    end
    tick();
    chk("sim_no_extra_r_o", 32'(if_rr.r_o), 32'h0);
    chk("sim_no_extra_a_i", 32'(if_rr.a_i), 32'hF);

    // Backpressure: consumer holds its ack for 20 cycles.
    if_rr.d_i[15:8] = 8'h77;
    if_rr.r_i[1]    = 1'b0;
    tick();
    chk("bp_r_o",   32'(if_rr.r_o), 32'h1);
    chk("bp_grant", 32'(g_rr), 32'h1);
    chk("bp_d_o",   32'(if_rr.d_o), 32'h77);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("bp_hold%0d_r_o", c), 32'(if_rr.r_o), 32'h1);
      chk($sformatf("bp_hold%0d_d_o", c), 32'(if_rr.d_o), 32'h77);
      chk($sformatf("bp_hold%0d_grant", c), 32'(g_rr), 32'h1);
      chk($sformatf("bp_hold%0d_a_i", c), 32'(if_rr.a_i), 32'hF);
    end
    if_rr.a_o = 1'b1;
    tick();
    chk("bp_release_a_i", 32'(if_rr.a_i), 32'hD);
    tick();
    chk("bp_once_a_i", 32'(if_rr.a_i), 32'hD);

    // Fixed priority: channels 1 and 3, channel 1 re-requests.
    if_fp.d_i = 32'h23002100;
    if_fp.r_i = 4'b1010;
    tick();
    chk("fp1_grant", 32'(g_fp), 32'h1);
    chk("fp1_d_o",   32'(if_fp.d_o), 32'h21);
    chk("fp1_r_o",   32'(if_fp.r_o), 32'h1);
    if_fp.a_o = 1'b1;
    tick();
    chk("fp1_a_i", 32'(if_fp.a_i), 32'h2);
    if_fp.r_i[1]    = 1'b0;
    if_fp.d_i[15:8] = 8'h31;
    tick();
    chk("fp2_grant", 32'(g_fp), 32'h1);
    chk("fp2_d_o",   32'(if_fp.d_o), 32'h31);
    chk("fp2_r_o",   32'(if_fp.r_o), 32'h0);
    if_fp.a_o = 1'b0;
    tick();
    chk("fp2_a_i", 32'(if_fp.a_i), 32'h0);
    tick();
    chk("fp3_grant", 32'(g_fp), 32'h3);
    chk("fp3_d_o",   32'(if_fp.d_o), 32'h23);
    chk("fp3_r_o",   32'(if_fp.r_o), 32'h1);
    if_fp.a_o = 1'b1;
    tick();
    chk("fp3_a_i", 32'(if_fp.a_i), 32'h8);

    // Synchronised variant: spurious ack, then 3-cycle request latency.
    if_sy.a_o = 1'b1;
    tick();
    tick();
    chk("sy_err_early", 32'(e_sy), 32'h0);
    tick();
    chk("sy_err_set",   32'(e_sy), 32'h1);
    chk("sy_err_a_i",   32'(if_sy.a_i), 32'h0);
    if_sy.a_o = 1'b0;
    repeat (4) tick();
    chk("sy_err_sticky", 32'(e_sy), 32'h1);
    if_sy.d_i[23:16] = 8'hA5;
    if_sy.r_i[2]     = 1'b1;
    tick();
    tick();
    chk("sy_req_early_r_o", 32'(if_sy.r_o), 32'h0);
    tick();
    chk("sy_req_r_o",   32'(if_sy.r_o), 32'h1);
    chk("sy_req_grant", 32'(g_sy), 32'h2);
    chk("sy_req_d_o",   32'(if_sy.d_o), 32'hA5);
    if_sy.a_o = 1'b1;
    tick();
    tick();
    chk("sy_ack_early_a_i", 32'(if_sy.a_i), 32'h0);
    tick();
    chk("sy_ack_a_i", 32'(if_sy.a_i), 32'h4);
    chk("sy_ack_busy", 32'(b_sy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
